// File: rtl/seq_detect_prog_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_prog_if
// Purpose  : Bundles the serial data, configuration and status signals of the
//            programmable pattern detector.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_detect_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
    logic               en;
    logic               Din;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               clr_count;
    logic               Z;
    logic [CNT_W-1:0]   match_count;
    logic [LEN_W-1:0]   fill;

    modport master (
        output en, Din, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
        input  Z, match_count, fill
    );

    modport slave (
        input  en, Din, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
        output Z, match_count, fill
    );
endinterface
`default_nettype wire

// File: rtl/seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_prog
// Purpose  : Run-time programmable serial bit-pattern detector with registered
//            Moore match flag, saturating match counter and fill indicator.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_prog #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  wire logic          CLK,
    input  wire logic          RESET,
    seq_detect_prog_if.slave   bus
);

    localparam int                 C_RST_LEN = (MAX_LEN < 5) ? MAX_LEN : 5;
    localparam logic [CNT_W-1:0]   C_CNT_MAX = '1;

    logic [MAX_LEN-1:0] r_hist, r_pat;
    logic [MAX_LEN-1:0] w_hist_nxt, w_pat_nxt, w_cand, w_mask;
    logic [LEN_W-1:0]   r_fill, r_len;
    logic [LEN_W-1:0]   w_fill_nxt, w_len_nxt, w_len_cfg;
    logic [LEN_W:0]     w_fill_inc;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_ovl, w_ovl_nxt;
    logic               r_z;
    logic               w_accept, w_match, w_full;

    assign w_accept   = bus.en && !bus.cfg_load;
    assign w_cand     = {r_hist[MAX_LEN-2:0], bus.Din};
    // Low r_len bits set; a shift of MAX_LEN yields an all-ones mask.
    assign w_mask     = ~({MAX_LEN{1'b1}} << r_len);
    assign w_fill_inc = {1'b0, r_fill} + (LEN_W+1)'(1);
    assign w_full     = (w_fill_inc >= {1'b0, r_len});
    assign w_match    = w_accept && w_full && (((w_cand ^ r_pat) & w_mask) == '0);

    always_comb begin
        w_len_cfg = bus.cfg_len;
        if (bus.cfg_len == '0) begin
            w_len_cfg = LEN_W'(1);
        end else if (bus.cfg_len > LEN_W'(MAX_LEN)) begin
            w_len_cfg = LEN_W'(MAX_LEN);
        end
    end

    always_comb begin
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        w_cnt_nxt  = r_cnt;
        w_pat_nxt  = r_pat;
        w_len_nxt  = r_len;
        w_ovl_nxt  = r_ovl;
        if (bus.cfg_load) begin
            w_pat_nxt  = bus.cfg_pattern;
            w_len_nxt  = w_len_cfg;
            w_ovl_nxt  = bus.cfg_overlap;
            w_hist_nxt = '0;
            w_fill_nxt = '0;
            w_cnt_nxt  = '0;
        end else begin
            if (w_accept) begin
                w_hist_nxt = w_cand;
                if (w_match && !r_ovl) begin
                    w_fill_nxt = '0;
                end else if (w_full) begin
                    w_fill_nxt = r_len;
                end else begin
                    w_fill_nxt = w_fill_inc[LEN_W-1:0];
                end
            end
            // A match coinciding with a clear counts as the first new match.
            if (bus.clr_count) begin
                w_cnt_nxt = w_match ? CNT_W'(1) : '0;
            end else if (w_match && (r_cnt != C_CNT_MAX)) begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= MAX_LEN'(5'b11011);
            r_len  <= LEN_W'(C_RST_LEN);
            r_ovl  <= 1'b1;
            r_z    <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
            r_pat  <= w_pat_nxt;
            r_len  <= w_len_nxt;
            r_ovl  <= w_ovl_nxt;
            r_z    <= w_match;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign bus.Z           = r_z;
    assign bus.match_count = r_cnt;
    assign bus.fill        = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_prog.sv
`default_nettype none
// Testbench for seq_detect_prog: directed scenarios plus random traffic,
// scored against a bit-queue reference model.
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    always #5 CLK = ~CLK;

    seq_detect_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) sif ();

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (sif.slave)
    );

    typedef struct {
        bit z;
        int cnt;
        int fill;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: accepted bits kept as a queue, newest at the back.
    bit         mbits[$];
    logic [7:0] mpat;
    int         mlen;
    bit         movl;
    int         mfill;
    int         mcount;

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mbits.delete();
        mpat   = 8'b11011;
        mlen   = 5;
        movl   = 1'b1;
        mfill  = 0;
        mcount = 0;
    endtask

    // Drive one cycle of inputs, predict the outcome of the next edge, queue it.
    task automatic cyc(input bit en, input bit din, input bit load = 1'b0,
                       input logic [7:0] p = 8'h00, input int l = 0,
                       input bit o = 1'b0, input bit clr = 1'b0);
        exp_t e;
        bit   m;
        int   n;
        sif.en          = en;
        sif.Din         = din;
        sif.cfg_load    = load;
        sif.cfg_pattern = p;
        sif.cfg_len     = LEN_W'(l);
        sif.cfg_overlap = o;
        sif.clr_count   = clr;
        m = 1'b0;
        if (load) begin
            mpat   = p;
            mlen   = (l == 0) ? 1 : ((l > MAX_LEN) ? MAX_LEN : l);
            movl   = o;
            mbits.delete();
            mfill  = 0;
            mcount = 0;
        end else begin
            if (en) begin
                mbits.push_back(din);
                if (mbits.size() > MAX_LEN) void'(mbits.pop_front());
                n = mbits.size();
                m = (mfill + 1 >= mlen) && (n >= mlen);
                for (int k = 0; k < mlen && k < n; k++)
                    if (mbits[n-1-k] != mpat[k]) m = 1'b0;
                if (m && !movl) mfill = 0;
                else            mfill = (mfill + 1 > mlen) ? mlen : mfill + 1;
            end
            if (clr)                         mcount = m ? 1 : 0;
            else if (m && mcount < CNT_MAX)  mcount++;
        end
        e.z    = m;
        e.cnt  = mcount;
        e.fill = mfill;
        expq.push_back(e);
        @(negedge CLK);
    endtask

    task automatic feed(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, bits[i]);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once.
    task automatic rst_pulse();
        #2;
        sif.en = 1'b0;
        RESET  = 1'b1;
        #1;
        cmp("rst_async_Z", int'(sif.Z), 0);
        cmp("rst_async_count", int'(sif.match_count), 0);
        cmp("rst_async_fill", int'(sif.fill), 0);
        RESET = 1'b0;
        model_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                cmp("Z", int'(sif.Z), int'(e.z));
                cmp("match_count", int'(sif.match_count), e.cnt);
                cmp("fill", int'(sif.fill), e.fill);
            end
        end
    end

    initial begin : driver
        int   r;
        int   l;
        bit   e;
        sif.en = 1'b0; sif.Din = 1'b0; sif.cfg_load = 1'b0; sif.cfg_pattern = '0;
        sif.cfg_len = '0; sif.cfg_overlap = 1'b0; sif.clr_count = 1'b0;
        model_reset();
        @(negedge CLK);
        cmp("reset_Z", int'(sif.Z), 0);
        cmp("reset_count", int'(sif.match_count), 0);
        cmp("reset_fill", int'(sif.fill), 0);
        RESET = 1'b0;

        // Default 11011 overlapping detector
        feed(32'b11011011, 8);
        cmp("t1_count", int'(sif.match_count), 2);

        // Non-overlapping
        cyc(1'b0, 1'b0, 1'b1, 8'b11011, 5, 1'b0);
        feed(32'b11011011, 8);
        cmp("t2_count", int'(sif.match_count), 1);
        cmp("t2_fill", int'(sif.fill), 3);

        // Single-bit pattern, back-to-back matches, saturation, clear+match
        cyc(1'b0, 1'b0, 1'b1, 8'h01, 1, 1'b1);
        feed(32'b11110, 5);
        cmp("t3_count", int'(sif.match_count), 4);
        repeat (300) cyc(1'b1, 1'b1);
        cmp("t3_sat", int'(sif.match_count), CNT_MAX);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1);
        cmp("t3_clr_match", int'(sif.match_count), 1);

        // en gaps
        cyc(1'b0, 1'b0, 1'b1, 8'b11011, 5, 1'b1);
        feed(32'b110, 3);
        for (int i = 0; i < 3; i++) cyc(1'b0, i[0]);
        feed(32'b11, 2);
        cmp("t4_count", int'(sif.match_count), 1);

        // Reload mid-stream, then over-length configuration
        feed(32'b101101, 6);
        cyc(1'b1, 1'b1, 1'b1, 8'hA5, 8, 1'b1);
        feed(32'hA5, 8);
        cmp("t5_count", int'(sif.match_count), 1);
        cyc(1'b0, 1'b0, 1'b1, 8'hFF, 12, 1'b1);
        feed(32'h0, 10);
        cmp("t5_fill_cap", int'(sif.fill), 8);

        // Asynchronous reset mid-pattern
        cyc(1'b0, 1'b0, 1'b1, 8'b11011, 5, 1'b1);
        feed(32'b11011, 5);
        feed(32'b1101, 4);
        cmp("t6_pre_count", int'(sif.match_count), 1);
        rst_pulse();
        feed(32'b1, 1);
        cmp("t6_stale", int'(sif.match_count), 0);
        feed(32'b1011, 4);
        cmp("t6_fresh", int'(sif.match_count), 1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                l = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : $urandom_range(0, 12);
                cyc(1'($urandom), 1'($urandom), 1'b1, 8'($urandom), l, 1'($urandom), 1'($urandom));
            end else begin
                e = (r < 80);
                cyc(e, 1'($urandom), 1'b0, 8'h00, 0, 1'b0, e && ($urandom_range(0, 39) == 0));
            end
        end

        sif.en = 1'b0; sif.cfg_load = 1'b0; sif.clr_count = 1'b0;
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge CLK);
        cmp("drain", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
